// File: rtl/sophon_test_monitor_if.sv
// Bundle of the monitor's observed core signals and its verdict outputs.
// The bench drives through the master view; the monitor uses the slave view.
interface sophon_test_monitor_if #(
  parameter int NUM_HART = 1,
  parameter int TO_BIT   = 18
);
  logic                    en_i;
  logic [NUM_HART-1:0]     ecall_i;
  logic [32*NUM_HART-1:0]  gp_i;
  logic [NUM_HART-1:0]     hart_done_o;
  logic [NUM_HART-1:0]     hart_fail_o;
  logic                    done_o;
  logic                    pass_o;
  logic                    fail_o;
  logic                    timeout_o;
  logic [31:0]             fail_gp_o;
  logic [TO_BIT-1:0]       cycle_cnt_o;

  modport master (
    output en_i, ecall_i, gp_i,
    input  hart_done_o, hart_fail_o, done_o, pass_o, fail_o, timeout_o,
           fail_gp_o, cycle_cnt_o
  );

  modport slave (
    input  en_i, ecall_i, gp_i,
    output hart_done_o, hart_fail_o, done_o, pass_o, fail_o, timeout_o,
           fail_gp_o, cycle_cnt_o
  );
endinterface

// File: rtl/sophon_test_monitor.sv
// Multi-hart end-of-test monitor: ecall -> drain -> gp judgement per hart,
// plus a saturating global timeout and sticky registered verdicts.
module sophon_test_monitor #(
  parameter int          NUM_HART  = 1,
  parameter int          TO_BIT    = 18,
  parameter int          DRAIN_CYC = 255,
  parameter logic [31:0] PASS_CODE = 32'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sophon_test_monitor_if.slave mon_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } hart_st_e;

  localparam logic [7:0]        DRAIN_LAST = 8'(DRAIN_CYC - 1);
  localparam logic [TO_BIT-1:0] CNT_MAX    = {TO_BIT{1'b1}};
  localparam logic [TO_BIT-1:0] CNT_ONE    = TO_BIT'(1);

  hart_st_e              hart_st_q   [NUM_HART];
  hart_st_e              hart_st_d   [NUM_HART];
  logic [7:0]            drain_cnt_q [NUM_HART];
  logic [7:0]            drain_cnt_d [NUM_HART];
  logic [NUM_HART-1:0]   hart_done_q, hart_done_d;
  logic [NUM_HART-1:0]   hart_fail_q, hart_fail_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           fail_gp_q, fail_gp_d;
  logic [TO_BIT-1:0]     cycle_cnt_q, cycle_cnt_d;

  logic                  active_s;
  logic                  gp_taken_s;
  logic [31:0]           gp_s;

  // Next-state for the per-hart FSMs, fail-gp capture, counter and verdicts.
  always_comb begin
    active_s   = mon_if.en_i & ~done_q;
    gp_taken_s = |hart_fail_q;
    gp_s       = 32'h0;
    fail_gp_d  = fail_gp_q;
    for (int h = 0; h < NUM_HART; h++) begin
      hart_st_d[h]   = hart_st_q[h];
      drain_cnt_d[h] = drain_cnt_q[h];
      gp_s           = mon_if.gp_i[32*h +: 32];
      if (active_s) begin
        case (hart_st_q[h])
          ST_IDLE: begin
            if (mon_if.ecall_i[h]) begin
              hart_st_d[h]   = ST_DRAIN;
              drain_cnt_d[h] = 8'd0;
            end else begin
              hart_st_d[h]   = ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_q[h] == DRAIN_LAST) begin
              if (gp_s == PASS_CODE) begin
                hart_st_d[h] = ST_PASS;
              end else begin
                hart_st_d[h] = ST_FAIL;
                // Ascending loop order makes the lowest failing index win.
                if (!gp_taken_s) begin
                  fail_gp_d  = gp_s;
                  gp_taken_s = 1'b1;
                end else begin
                  fail_gp_d  = fail_gp_d;
                end
              end
            end else begin
              drain_cnt_d[h] = drain_cnt_q[h] + 8'd1;
            end
          end
          ST_PASS: hart_st_d[h] = ST_PASS;
          ST_FAIL: hart_st_d[h] = ST_FAIL;
          default: hart_st_d[h] = ST_IDLE;
        endcase
      end else begin
        hart_st_d[h] = hart_st_q[h];
      end
      hart_done_d[h] = (hart_st_d[h] == ST_PASS) || (hart_st_d[h] == ST_FAIL);
      hart_fail_d[h] = (hart_st_d[h] == ST_FAIL);
    end

    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    if (active_s && (cycle_cnt_q != CNT_MAX)) begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      // A hart resolving on the saturating edge beats the timeout.
      if ((cycle_cnt_d == CNT_MAX) && !(&hart_done_d)) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end

    done_d = done_q | (&hart_done_q) | timeout_d;
    pass_d = done_d & (&(hart_done_q & ~hart_fail_q)) & ~timeout_d;
    fail_d = fail_q | (|hart_fail_q);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int h = 0; h < NUM_HART; h++) begin
        hart_st_q[h]   <= ST_IDLE;
        drain_cnt_q[h] <= 8'd0;
      end
      hart_done_q <= {NUM_HART{1'b0}};
      hart_fail_q <= {NUM_HART{1'b0}};
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_gp_q   <= 32'h0;
      cycle_cnt_q <= {TO_BIT{1'b0}};
    end else begin
      hart_st_q   <= hart_st_d;
      drain_cnt_q <= drain_cnt_d;
      hart_done_q <= hart_done_d;
      hart_fail_q <= hart_fail_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_gp_q   <= fail_gp_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign mon_if.hart_done_o = hart_done_q;
  assign mon_if.hart_fail_o = hart_fail_q;
  assign mon_if.done_o      = done_q;
  assign mon_if.pass_o      = pass_q;
  assign mon_if.fail_o      = fail_q;
  assign mon_if.timeout_o   = timeout_q;
  assign mon_if.fail_gp_o   = fail_gp_q;
  assign mon_if.cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_sophon_test_monitor.sv
// Directed bench for sophon_test_monitor (2 harts, 8-bit timeout, drain 4).
// Edge N is the N-th rising edge after reset release, counting from 0.
module tb_sophon_test_monitor;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  sophon_test_monitor_if #(.NUM_HART(2), .TO_BIT(8)) mon_if ();

  sophon_test_monitor #(
    .NUM_HART (2),
    .TO_BIT   (8),
    .DRAIN_CYC(4),
    .PASS_CODE(32'd1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .mon_if(mon_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic en, input logic [1:0] ec, input logic [31:0] g0,
                     input logic [31:0] g1);
    mon_if.en_i    = en;
    mon_if.ecall_i = ec;
    mon_if.gp_i    = {g1, g0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hd"},   {30'd0, mon_if.hart_done_o}, 32'd0);
    chk({tag, "_hf"},   {30'd0, mon_if.hart_fail_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, mon_if.done_o},      32'd0);
    chk({tag, "_pass"}, {31'd0, mon_if.pass_o},      32'd0);
    chk({tag, "_fail"}, {31'd0, mon_if.fail_o},      32'd0);
    chk({tag, "_to"},   {31'd0, mon_if.timeout_o},   32'd0);
    chk({tag, "_gp"},   mon_if.fail_gp_o,            32'd0);
    chk({tag, "_cnt"},  {24'd0, mon_if.cycle_cnt_o}, 32'd0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    drv(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset values
    #3;
    chk_all_zero("rst");

    // Both harts pass
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      drv(1'b1, (e == 10) ? 2'b01 : ((e == 20) ? 2'b10 : 2'b00), 32'd1, 32'd1);
      tick();
      if (e == 13) chk("p_hd13", {30'd0, mon_if.hart_done_o}, 32'd0);
      if (e == 14) chk("p_hd14", {30'd0, mon_if.hart_done_o}, 32'd1);
      if (e == 23) chk("p_hd23", {30'd0, mon_if.hart_done_o}, 32'd1);
      if (e == 24) begin
        chk("p_hd24",   {30'd0, mon_if.hart_done_o}, 32'd3);
        chk("p_done24", {31'd0, mon_if.done_o},      32'd0);
      end
      if (e == 25) begin
        chk("p_done25", {31'd0, mon_if.done_o}, 32'd1);
        chk("p_pass25", {31'd0, mon_if.pass_o}, 32'd1);
        chk("p_fail25", {31'd0, mon_if.fail_o}, 32'd0);
      end
    end
    chk("p_cnt",  {24'd0, mon_if.cycle_cnt_o}, 32'd26);
    chk("p_hf",   {30'd0, mon_if.hart_fail_o}, 32'd0);
    chk("p_pass", {31'd0, mon_if.pass_o},      32'd1);

    // Hart 1 fails, hart 0 passes later
    do_reset();
    for (int e = 0; e <= 18; e++) begin
      drv(1'b1, (e == 5) ? 2'b10 : ((e == 12) ? 2'b01 : 2'b00), 32'd1, 32'hDEAD);
      tick();
      if (e == 8) chk("f_hf8", {30'd0, mon_if.hart_fail_o}, 32'd0);
      if (e == 9) begin
        chk("f_hf9",   {30'd0, mon_if.hart_fail_o}, 32'd2);
        chk("f_fail9", {31'd0, mon_if.fail_o},      32'd0);
      end
      if (e == 10) begin
        chk("f_fail10", {31'd0, mon_if.fail_o}, 32'd1);
        chk("f_gp10",   mon_if.fail_gp_o,       32'hDEAD);
        chk("f_done10", {31'd0, mon_if.done_o}, 32'd0);
      end
      if (e == 16) chk("f_done16", {31'd0, mon_if.done_o}, 32'd0);
      if (e == 17) begin
        chk("f_done17", {31'd0, mon_if.done_o}, 32'd1);
        chk("f_pass17", {31'd0, mon_if.pass_o}, 32'd0);
        chk("f_hd17",   {30'd0, mon_if.hart_done_o}, 32'd3);
      end
    end
    chk("f_gp_end", mon_if.fail_gp_o, 32'hDEAD);

    // Simultaneous failure, lowest index supplies fail_gp
    do_reset();
    for (int e = 0; e <= 9; e++) begin
      drv(1'b1, (e == 3) ? 2'b11 : 2'b00, 32'd7, 32'd9);
      tick();
    end
    chk("s_gp",   mon_if.fail_gp_o,            32'd7);
    chk("s_done", {31'd0, mon_if.done_o},      32'd1);
    chk("s_fail", {31'd0, mon_if.fail_o},      32'd1);
    chk("s_pass", {31'd0, mon_if.pass_o},      32'd0);
    chk("s_hf",   {30'd0, mon_if.hart_fail_o}, 32'd3);

    // Timeout with no ecall
    do_reset();
    for (int e = 0; e <= 254; e++) begin
      drv(1'b1, 2'b00, 32'd1, 32'd1);
      tick();
      if (e == 253) begin
        chk("t_cnt253", {24'd0, mon_if.cycle_cnt_o}, 32'd254);
        chk("t_to253",  {31'd0, mon_if.timeout_o},   32'd0);
      end
    end
    chk("t_cnt",  {24'd0, mon_if.cycle_cnt_o}, 32'd255);
    chk("t_to",   {31'd0, mon_if.timeout_o},   32'd1);
    chk("t_done", {31'd0, mon_if.done_o},      32'd1);
    chk("t_pass", {31'd0, mon_if.pass_o},      32'd0);
    repeat (50) tick();
    chk("t_hold", {24'd0, mon_if.cycle_cnt_o}, 32'd255);
    drv(1'b1, 2'b11, 32'd1, 32'd1);
    tick();
    drv(1'b1, 2'b00, 32'd1, 32'd1);
    repeat (10) tick();
    chk("t_late_hd", {30'd0, mon_if.hart_done_o}, 32'd0);

    // Enable gating and ignored re-ecall; gp is good only while driving edge 17
    do_reset();
    for (int e = 0; e <= 18; e++) begin
      drv((e >= 11 && e <= 13) ? 1'b0 : 1'b1,
          (e == 10 || e == 12 || e == 15) ? 2'b01 : 2'b00,
          (e == 17) ? 32'd1 : 32'h55, 32'd1);
      tick();
      if (e == 16) chk("g_hd16", {30'd0, mon_if.hart_done_o}, 32'd0);
      if (e == 17) begin
        chk("g_hd17", {30'd0, mon_if.hart_done_o}, 32'd1);
        chk("g_hf17", {30'd0, mon_if.hart_fail_o}, 32'd0);
      end
    end

    // Asynchronous reset while hart 1 is draining
    do_reset();
    for (int e = 0; e <= 7; e++) begin
      drv(1'b1, (e == 2) ? 2'b01 : ((e == 4) ? 2'b10 : 2'b00), 32'd1, 32'd1);
      tick();
    end
    chk("a_hd_pre", {30'd0, mon_if.hart_done_o}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("a_rst");
    #2;
    rst_n = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      drv(1'b1, 2'b00, 32'd1, 32'd1);
      tick();
    end
    chk("a_idle_hd",  {30'd0, mon_if.hart_done_o}, 32'd0);
    chk("a_idle_dn",  {31'd0, mon_if.done_o},      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sophon_test_monitor.md
# sophon_test_monitor

Synthesizable, parametrised end-of-test monitor for SOPHON simulation and FPGA self-test builds. It watches per-hart `ecall` retirement and the `gp` (x3) result register, waits a configurable drain period, then judges pass/fail per hart. It also runs a global saturating timeout and exposes sticky registered verdicts for a bench, an FPGA LED, or a status CSR. It supersedes the fixed single-hart finish/timeout counters in the top-level bench with a multi-hart, gated, reusable block.

## Interface
- `NUM_HART`, 1: number of harts monitored, legal 1..8.
- `TO_BIT`, 18: timeout counter width; timeout fires when the counter reaches 2^TO_BIT-1.
- `DRAIN_CYC`, 255: cycles from ecall sample to gp sample, legal 1..255.
- `PASS_CODE`, 32'd1: gp value judged as pass.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en_i`  in  1  monitor enable; all counters and FSMs hold while low.
- `ecall_i`  in  NUM_HART  per-hart ecall-retire indication, bit h = hart h.
- `gp_i`  in  32*NUM_HART  hart h gp at `[32*h +: 32]`.
- `hart_done_o`  out  NUM_HART  hart reached PASS or FAIL.
- `hart_fail_o`  out  NUM_HART  hart reached FAIL.
- `done_o`  out  1  all harts terminal, or timeout.
- `pass_o`  out  1  all harts PASS and no timeout.
- `fail_o`  out  1  any hart FAIL.
- `timeout_o`  out  1  timeout reached before all harts terminal.
- `fail_gp_o`  out  32  gp captured by the lowest-index failing hart.
- `cycle_cnt_o`  out  TO_BIT  enabled cycles elapsed since reset.

## Operation
- Per-hart FSM, states IDLE, DRAIN, PASS, FAIL; 8-bit drain counter per hart.
  - IDLE: if `en_i & ecall_i[h]`, go to DRAIN and clear the drain counter.
  - DRAIN: on each `en_i` cycle, increment the counter. When counter == DRAIN_CYC-1 and `en_i`, sample `gp_i[h]`: go to PASS if it equals PASS_CODE, otherwise go to FAIL. Further ecall pulses in DRAIN are ignored and do not restart the drain.
  - PASS and FAIL are terminal until reset.
- `fail_gp_o`: loaded once, by the first hart to enter FAIL. If several harts enter FAIL on the same edge, the lowest index wins. Later failures do not overwrite it.
- Global cycle counter:
  - Increments when `en_i & ~done_o`.
  - Saturates at all-ones. It never wraps.
- `timeout_o` is set on the edge where the counter becomes all-ones while not every hart is terminal. It is sticky.
- Simultaneous events: if the last hart resolves on the same edge the counter saturates, hart resolution wins and `timeout_o` stays 0.
- `done_o` is set when every hart is terminal or `timeout_o` is 1. It is sticky. After `done_o` rises, all FSMs freeze: late ecalls are ignored and harts still in DRAIN stay there.
- `pass_o` = `done_o` & all harts PASS & `~timeout_o`. `fail_o` is set as soon as any hart enters FAIL, independent of `done_o`.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Timing
- Reset values: every output is 0 (`fail_gp_o` = 32'h0, `cycle_cnt_o` = 0), and all FSMs are in IDLE.
- Let edge E0 be the one that samples `ecall_i[h]`=1 with `en_i`=1. With `en_i` held high:
  - gp is sampled at edge E0+DRAIN_CYC.
  - `hart_done_o[h]` and `hart_fail_o[h]` are visible after that edge.
  - `done_o`, `pass_o` and `fail_o` are visible one edge later (E0+DRAIN_CYC+1).
- Each `en_i`=0 cycle delays every latency above by exactly one cycle.
- `timeout_o` and `done_o` both rise after the edge where `cycle_cnt_o` becomes 2^TO_BIT-1.
- Reset asserted mid-drain or after done returns everything to reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: NUM_HART=2, TO_BIT=8, DRAIN_CYC=4, PASS_CODE=1.
- Both harts pass: ecall[0] at cycle 10 with gp0=1; ecall[1] at cycle 20 with gp1=1. Expect `hart_done_o`=2'b01 after edge 14 and 2'b11 after edge 24; `done_o`=`pass_o`=1 after edge 25; `fail_o`=0; `cycle_cnt_o` frozen at 26.
- Hart 1 fails: ecall[1] with gp1=32'hDEAD at cycle 5. Expect `hart_fail_o`=2'b10 after edge 9, `fail_o`=1 at edge 10, `fail_gp_o`=32'hDEAD, `done_o`=0 until hart 0 resolves.
- Simultaneous fail: both ecalls at cycle 3, gp0=7, gp1=9. Expect `fail_gp_o`=7, `done_o`=`fail_o`=1, `pass_o`=0.
- Timeout: no ecall. Expect `cycle_cnt_o`=255, then `timeout_o`=`done_o`=1 and `pass_o`=0. Counter holds 255 for 50 more cycles. An ecall after the timeout leaves `hart_done_o`=0.
- Enable gating and re-ecall: ecall[0] at cycle 10, `en_i`=0 for cycles 11-13, second ecall[0] at cycle 12. Expect the gp sample at edge 17 (not 14 or 16), and the drain counter not restarted.
- Async reset during DRAIN: assert `rst_ni`=0 mid-cycle. Expect all outputs 0 before the next clock edge, and the FSMs back in IDLE.
